// File: rtl/mul_unit_iter.sv
// -----------------------------------------------------------------------------
// mul_unit_iter
//
// Multi-cycle integer multiply / multiply-accumulate execution unit that sits
// directly behind the ARM standard decoder. A request is accepted in IDLE,
// the 32x32 product is built with a 32x8 shift-add step per CALC cycle, the
// ACC cycle applies the sign fix-up and the accumulate addend, and the WB
// cycle presents a one-cycle register-file writeback plus N/Z flag update.
//
// Timeline from the accept edge: 4 CALC cycles, 1 ACC cycle, 1 WB cycle.
// busy is high for all 6 cycles so the issue stage stalls.
//
// Ports
//   clk               core clock (all state updates on posedge)
//   rst_n             synchronous active-low reset
//   mul_en            multiply request from decoder
//   instruction_valid condition-code pass from decoder
//   mul_mode          00/01 short (32-bit), 10 long unsigned, 11 long signed
//   op1               multiplier (Rs)
//   op2               multiplicand (Rm)
//   ops_l, ops_h      accumulate addend low/high words (zero when no accumulate)
//   rd_en, rd_id      primary destination enable / ID
//   rd2_en, rd2_id    secondary (high word) destination enable / ID
//   psr_wr_cond_en    NZCV write mask from decoder
//   flush             pipeline abort
//   busy              unit occupied; new requests ignored
//   done              one-cycle completion pulse
//   wb_en/id/data     low-word writeback
//   wb2_en/id/data    high-word writeback (long modes only)
//   flag_wr_en        NZCV write enables (only N and Z can be set)
//   flag_nzcv         {N, Z, 0, 0}
// -----------------------------------------------------------------------------
module mul_unit_iter #(
  parameter int ITER_BITS = 8  // multiplier bits consumed per CALC cycle; only 8 supported
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mul_en,
  input  logic        instruction_valid,
  input  logic [1:0]  mul_mode,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [31:0] ops_l,
  input  logic [31:0] ops_h,
  input  logic        rd_en,
  input  logic        rd2_en,
  input  logic [4:0]  rd_id,
  input  logic [4:0]  rd2_id,
  input  logic [3:0]  psr_wr_cond_en,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic        wb_en,
  output logic [4:0]  wb_id,
  output logic [31:0] wb_data,
  output logic        wb2_en,
  output logic [4:0]  wb2_id,
  output logic [31:0] wb2_data,
  output logic [3:0]  flag_wr_en,
  output logic [3:0]  flag_nzcv
);

  localparam int         N_CALC   = 32 / ITER_BITS;
  localparam logic [1:0] LAST_CNT = 2'(N_CALC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ACC  = 2'd2,
    WB   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State and latched operation context
  // ---------------------------------------------------------------------------
  state_t      state_q,   state_d;
  logic [1:0]  cnt_q,     cnt_d;
  logic [31:0] mcand_q,   mcand_d;    // |op2| for signed, op2 otherwise
  logic [31:0] mplier_q,  mplier_d;   // |op1| for signed, op1 otherwise
  logic [63:0] acc_q,     acc_d;      // unsigned magnitude product being built
  logic        neg_q,     neg_d;      // final product must be negated
  logic        long_q,    long_d;
  logic [31:0] add_l_q,   add_l_d;
  logic [31:0] add_h_q,   add_h_d;
  logic        rd_en_l_q,  rd_en_l_d;
  logic        rd2_en_l_q, rd2_en_l_d;
  logic [4:0]  rd_id_l_q,  rd_id_l_d;
  logic [4:0]  rd2_id_l_q, rd2_id_l_d;
  logic [3:0]  mask_q,    mask_d;

  // Registered outputs
  logic        done_q,       done_d;
  logic        wb_en_q,      wb_en_d;
  logic [4:0]  wb_id_q,      wb_id_d;
  logic [31:0] wb_data_q,    wb_data_d;
  logic        wb2_en_q,     wb2_en_d;
  logic [4:0]  wb2_id_q,     wb2_id_d;
  logic [31:0] wb2_data_q,   wb2_data_d;
  logic [3:0]  flag_wr_en_q, flag_wr_en_d;
  logic [3:0]  flag_nzcv_q,  flag_nzcv_d;

  // ---------------------------------------------------------------------------
  // Operand setup at accept: signed mode works on magnitudes and remembers the
  // sign of the product. 0x80000000 negates to itself, which is exactly its
  // unsigned magnitude, so no special case is needed.
  // ---------------------------------------------------------------------------
  logic        accept;
  logic        signed_mode;
  logic [31:0] op1_mag;
  logic [31:0] op2_mag;

  assign accept      = mul_en & instruction_valid & ~flush;
  assign signed_mode = (mul_mode == 2'b11);
  assign op1_mag     = (signed_mode && op1[31]) ? (~op1 + 32'd1) : op1;
  assign op2_mag     = (signed_mode && op2[31]) ? (~op2 + 32'd1) : op2;

  // ---------------------------------------------------------------------------
  // Shift-add step: one multiplier slice per CALC cycle.
  // ---------------------------------------------------------------------------
  logic [ITER_BITS-1:0]    mplier_slice [N_CALC];
  logic [ITER_BITS-1:0]    cur_slice;
  logic [ITER_BITS+31:0]   partial;
  logic [63:0]             partial_shifted;
  logic [5:0]              shift_amt;

  generate
    for (genvar gi = 0; gi < N_CALC; gi++) begin : g_slice
      assign mplier_slice[gi] = mplier_q[gi*ITER_BITS +: ITER_BITS];
    end
  endgenerate

  assign cur_slice       = mplier_slice[cnt_q];
  assign partial         = {{ITER_BITS{1'b0}}, mcand_q} * {32'b0, cur_slice};
  assign shift_amt       = 6'(int'(cnt_q) * ITER_BITS);
  assign partial_shifted = {{(32 - ITER_BITS){1'b0}}, partial} << shift_amt;

  // ---------------------------------------------------------------------------
  // ACC datapath: sign fix-up, then the accumulate addend. Short mode ignores
  // the high addend word and only the low 32 bits of the result matter.
  // ---------------------------------------------------------------------------
  logic [63:0] product;
  logic [63:0] addend;
  logic [63:0] result;
  logic        res_n;
  logic        res_z;

  assign product = neg_q ? (~acc_q + 64'd1) : acc_q;
  assign addend  = long_q ? {add_h_q, add_l_q} : {32'b0, add_l_q};
  assign result  = product + addend;
  assign res_n   = long_q ? result[63] : result[31];
  assign res_z   = long_q ? (result == 64'd0) : (result[31:0] == 32'd0);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    acc_d        = acc_q;
    neg_d        = neg_q;
    long_d       = long_q;
    add_l_d      = add_l_q;
    add_h_d      = add_h_q;
    rd_en_l_d    = rd_en_l_q;
    rd2_en_l_d   = rd2_en_l_q;
    rd_id_l_d    = rd_id_l_q;
    rd2_id_l_d   = rd2_id_l_q;
    mask_d       = mask_q;

    // Pulse outputs default low; data/ID outputs hold.
    done_d       = 1'b0;
    wb_en_d      = 1'b0;
    wb2_en_d     = 1'b0;
    flag_wr_en_d = 4'b0000;
    wb_id_d      = wb_id_q;
    wb_data_d    = wb_data_q;
    wb2_id_d     = wb2_id_q;
    wb2_data_d   = wb2_data_q;
    flag_nzcv_d  = flag_nzcv_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = CALC;
          cnt_d      = 2'd0;
          acc_d      = 64'd0;
          mplier_d   = op1_mag;
          mcand_d    = op2_mag;
          neg_d      = signed_mode & (op1[31] ^ op2[31]);
          long_d     = mul_mode[1];
          add_l_d    = ops_l;
          add_h_d    = ops_h;
          rd_en_l_d  = rd_en;
          rd2_en_l_d = rd2_en;
          rd_id_l_d  = rd_id;
          rd2_id_l_d = rd2_id;
          mask_d     = psr_wr_cond_en;
        end
      end

      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_q + partial_shifted;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == LAST_CNT) begin
            state_d = ACC;
          end
        end
      end

      ACC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          // Everything seen in the WB cycle is registered here.
          state_d      = WB;
          done_d       = 1'b1;
          wb_en_d      = rd_en_l_q;
          wb_id_d      = rd_id_l_q;
          wb_data_d    = result[31:0];
          wb2_en_d     = rd2_en_l_q & long_q;
          wb2_id_d     = rd2_id_l_q;
          wb2_data_d   = long_q ? result[63:32] : 32'd0;
          flag_wr_en_d = mask_q & 4'b1100;
          flag_nzcv_d  = {res_n, res_z, 2'b00};
        end
      end

      WB: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      mcand_q      <= 32'd0;
      mplier_q     <= 32'd0;
      acc_q        <= 64'd0;
      neg_q        <= 1'b0;
      long_q       <= 1'b0;
      add_l_q      <= 32'd0;
      add_h_q      <= 32'd0;
      rd_en_l_q    <= 1'b0;
      rd2_en_l_q   <= 1'b0;
      rd_id_l_q    <= 5'd0;
      rd2_id_l_q   <= 5'd0;
      mask_q       <= 4'd0;
      done_q       <= 1'b0;
      wb_en_q      <= 1'b0;
      wb_id_q      <= 5'd0;
      wb_data_q    <= 32'd0;
      wb2_en_q     <= 1'b0;
      wb2_id_q     <= 5'd0;
      wb2_data_q   <= 32'd0;
      flag_wr_en_q <= 4'd0;
      flag_nzcv_q  <= 4'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      acc_q        <= acc_d;
      neg_q        <= neg_d;
      long_q       <= long_d;
      add_l_q      <= add_l_d;
      add_h_q      <= add_h_d;
      rd_en_l_q    <= rd_en_l_d;
      rd2_en_l_q   <= rd2_en_l_d;
      rd_id_l_q    <= rd_id_l_d;
      rd2_id_l_q   <= rd2_id_l_d;
      mask_q       <= mask_d;
      done_q       <= done_d;
      wb_en_q      <= wb_en_d;
      wb_id_q      <= wb_id_d;
      wb_data_q    <= wb_data_d;
      wb2_en_q     <= wb2_en_d;
      wb2_id_q     <= wb2_id_d;
      wb2_data_q   <= wb2_data_d;
      flag_wr_en_q <= flag_wr_en_d;
      flag_nzcv_q  <= flag_nzcv_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. The write strobes are already registered high for the WB cycle;
  // a flush arriving during that same cycle must still cancel them, so they
  // are masked by flush on the way out.
  // ---------------------------------------------------------------------------
  assign busy       = (state_q != IDLE);
  assign done       = done_q   & ~flush;
  assign wb_en      = wb_en_q  & ~flush;
  assign wb2_en     = wb2_en_q & ~flush;
  assign flag_wr_en = flag_wr_en_q & {4{~flush}};
  assign wb_id      = wb_id_q;
  assign wb_data    = wb_data_q;
  assign wb2_id     = wb2_id_q;
  assign wb2_data   = wb2_data_q;
  assign flag_nzcv  = flag_nzcv_q;

endmodule
